morse_decoder: RTL and testbench
================================

# morse_decoder

Receive-side counterpart of the Morse table/encoder path. The block samples a single on/off key line and measures mark and space durations in units of `UNIT_CYCLES` clocks. It assembles dots and dashes into a 16-bit code in the same format `morse_table` produces, then reverse-maps that code to lowercase ASCII. Output goes to the character sink (UART/display) as a one-cycle valid strobe.

## Interface
Parameters:
- `UNIT_CYCLES`, 5000000 — clock cycles per Morse unit (dot length); must be ≥ 2.
- `DATA_WIDTH`, 16 — code width; 2 bits per element, 8 elements maximum.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `key_in`  in  1  key line, asynchronous to `clk`; 1 = mark (tone), 0 = space.
- `ascii_out`  out  8  decoded character; held until the next strobe.
- `code_out`  out  DATA_WIDTH  raw assembled code for the character in `ascii_out`.
- `valid`  out  1  one-cycle strobe; `ascii_out` and `code_out` are valid while it is high.
- `err`  out  1  qualifies `valid`: code was unknown or longer than 8 elements.

## Operation
- Code format (shared with `morse_table`): elements are packed MSB-first, 2 bits each.
  - 10 = dot, 11 = dash, 00 = end/unused.
  - Example: 'a' (.-) = 0xB000.
- Input sync: `key_in` passes through a 2-flop synchronizer to give `key_s`. All edge detection uses `key_s`.
- Prescaler `pre` counts 0..UNIT_CYCLES-1.
  - It clears on every `key_s` edge and in IDLE.
  - A `tick` occurs when `pre == UNIT_CYCLES-1`.
  - Unit counter `units` (3 bits) increments on `tick`, saturates at 7, and clears on every `key_s` edge.
- States:
  - IDLE: `key_s` = 0, nothing accumulated.
    - On `key_s` rise, go to MARK.
  - MARK: count mark units.
    - On `key_s` fall, classify the element: `units` < 2 is a dot, ≥ 2 is a dash.
    - Shift the element into the shift register `sr` at slot `n`, increment element count `n`, go to SPACE.
    - If `n` is already 8, set `ovf` and discard the element.
  - SPACE: count gap units.
    - On `key_s` rise before `units` reaches 2, go to MARK (intra-character gap).
    - When `units` reaches 2, emit the character: `code_out <= sr`, `ascii_out <= lookup(sr)`, pulse `valid`. Then clear `sr`, `n` and `ovf`, and go to GAP.
  - GAP: character already emitted.
    - On `key_s` rise, go to MARK (new character).
    - When `units` reaches 5, emit a space: `ascii_out` = 0x20, `code_out` = 0, `valid` pulses, `err` = 0. Then go to IDLE.
- Lookup: full ITU set a–z (0x61–0x7A) and 0–9 (0x30–0x39), matching the `morse_table` contents.
  - An unmatched code, or `ovf` set, gives `ascii_out` = 0x3F ('?') with `err` = 1.
- At most one word-space is emitted per gap. IDLE never emits.

## Timing
- Reset values:
  - `ascii_out` = 0, `code_out` = 0, `valid` = 0, `err` = 0.
  - State = IDLE; `pre`, `units`, `sr`, `n`, `ovf` = 0.
  - Synchronizer flops = 0.
- Reset asserted mid-character discards the partial character with no strobe. After release, a key that is already high is seen as a rise once it has passed through the synchronizer.
- A mark held for exactly k·UNIT_CYCLES cycles yields `units` = k at the fall. Synchronizer delay cancels because both edges are delayed equally.
- Character strobe latency: `valid` is high in the cycle after the 2nd space tick, i.e. 2 + 2·UNIT_CYCLES + 1 clocks after `key_in` falls (±1 for input sampling phase).
- Word-space strobe: 3·UNIT_CYCLES clocks after the character strobe.
- `valid` is never high in two consecutive cycles. `err` is meaningful only while `valid` = 1 and reads 0 otherwise.
- A key edge in the same cycle as a tick takes priority: `units` clears and the state transitions. No emission occurs in that cycle.

## Test plan
- **Letter 'a':** UNIT_CYCLES = 4; send mark 4, space 4, mark 12, then space 28 → one `valid` with `ascii_out` = 0x61, `code_out` = 0xB000, `err` = 0. Then a second `valid` with `ascii_out` = 0x20.
- **Digit '0':** five 12-cycle marks separated by 4-cycle spaces, then a 12-cycle space → `ascii_out` = 0x30, `code_out` = 0xFFC0, `err` = 0. No word-space follows, because the key rises again before 5 units.
- **Classification boundary:** a 7-cycle mark → dot, 'e' (0x65, `code_out` 0x8000). An 8-cycle mark → dash, 't' (0x74, `code_out` 0xC000).
- **Error cases:** nine dots → `ascii_out` = 0x3F, `err` = 1. Pattern ..-- (0xAF00, unmapped) → 0x3F, `err` = 1.
- **Reset mid-character:** pulse `rst_n` low in the middle of the 2nd element → no `valid` is produced. The next clean 'e' decodes correctly.
- **Key held and gaps:** hold `key_in` high for 200 cycles → dash (`units` saturates), decodes as 't'. A 9-cycle space between marks → two separate characters, with no 0x20 between them.

Source files
------------

// File: rtl/morse_decoder.sv
// Morse receiver: times mark/space lengths on a synchronised key line, packs
// dots/dashes into a 2-bit-per-element code and maps it back to lowercase ASCII.
module morse_decoder #(
   parameter int UNIT_CYCLES = 5000000,
   parameter int DATA_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_in,
   output logic [7:0]            ascii_out,
   output logic [DATA_WIDTH-1:0] code_out,
   output logic                  valid,
   output logic                  err
);

   localparam int PW = $clog2(UNIT_CYCLES);

   typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

   state_t                state_q;
   logic                  meta_q, key_s_q, key_prev_q;
   logic [PW-1:0]         pre_q;
   logic [2:0]            units_q;
   logic [DATA_WIDTH-1:0] sr_q;
   logic [3:0]            n_q;
   logic                  ovf_q;
   logic [7:0]            ascii_q;
   logic [DATA_WIDTH-1:0] code_q;
   logic                  valid_q, err_q;

   logic                  key_edge, key_rise, key_fall, tick, is_dash, lut_hit;
   logic [DATA_WIDTH-1:0] sr_d;
   logic [7:0]            lut_char;

   assign key_edge = key_s_q ^ key_prev_q;
   assign key_rise = key_s_q & ~key_prev_q;
   assign key_fall = ~key_s_q & key_prev_q;
   assign tick     = (pre_q == PW'(UNIT_CYCLES - 1));

   // A tick landing on the falling edge still counts toward the mark length,
   // so a mark of exactly k units classifies as k units.
   assign is_dash  = (units_q >= 3'd2) || ((units_q == 3'd1) && tick);
   assign sr_d     = sr_q | ({1'b1, is_dash, {(DATA_WIDTH-2){1'b0}}} >> {n_q, 1'b0});

   always_comb begin
      lut_char = 8'h3F;
      case (sr_q)
         16'hB000: lut_char = 8'h61;  16'hEA00: lut_char = 8'h62;
         16'hEE00: lut_char = 8'h63;  16'hE800: lut_char = 8'h64;
         16'h8000: lut_char = 8'h65;  16'hAE00: lut_char = 8'h66;
         16'hF800: lut_char = 8'h67;  16'hAA00: lut_char = 8'h68;
         16'hA000: lut_char = 8'h69;  16'hBF00: lut_char = 8'h6A;
         16'hEC00: lut_char = 8'h6B;  16'hBA00: lut_char = 8'h6C;
         16'hF000: lut_char = 8'h6D;  16'hE000: lut_char = 8'h6E;
         16'hFC00: lut_char = 8'h6F;  16'hBE00: lut_char = 8'h70;
         16'hFB00: lut_char = 8'h71;  16'hB800: lut_char = 8'h72;
         16'hA800: lut_char = 8'h73;  16'hC000: lut_char = 8'h74;
         16'hAC00: lut_char = 8'h75;  16'hAB00: lut_char = 8'h76;
         16'hBC00: lut_char = 8'h77;  16'hEB00: lut_char = 8'h78;
         16'hEF00: lut_char = 8'h79;  16'hFA00: lut_char = 8'h7A;
         16'hFFC0: lut_char = 8'h30;  16'hBFC0: lut_char = 8'h31;
         16'hAFC0: lut_char = 8'h32;  16'hABC0: lut_char = 8'h33;
         16'hAAC0: lut_char = 8'h34;  16'hAA80: lut_char = 8'h35;
         16'hEA80: lut_char = 8'h36;  16'hFA80: lut_char = 8'h37;
         16'hFE80: lut_char = 8'h38;  16'hFF80: lut_char = 8'h39;
         default:  lut_char = 8'h3F;
      endcase
   end

   assign lut_hit = (lut_char != 8'h3F);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         meta_q     <= 1'b0;
         key_s_q    <= 1'b0;
         key_prev_q <= 1'b0;
         pre_q      <= '0;
         units_q    <= '0;
         sr_q       <= '0;
         n_q        <= '0;
         ovf_q      <= 1'b0;
         ascii_q    <= '0;
         code_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         meta_q     <= key_in;
         key_s_q    <= meta_q;
         key_prev_q <= key_s_q;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;

         if (state_q == IDLE || key_edge) begin
            pre_q   <= '0;
            units_q <= '0;
         end else begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick && units_q != 3'd7)
               units_q <= units_q + 3'd1;
         end

         // Edges are checked before tick-driven emission so an edge wins a tie.
         case (state_q)
            IDLE: if (key_rise) state_q <= MARK;
            MARK: if (key_fall) begin
               if (n_q == 4'd8) begin
                  ovf_q <= 1'b1;
               end else begin
                  sr_q <= sr_d;
                  n_q  <= n_q + 4'd1;
               end
               state_q <= SPACE;
            end
            SPACE: begin
               if (key_rise) begin
                  state_q <= MARK;
               end else if (tick && units_q == 3'd1) begin
                  code_q  <= sr_q;
                  ascii_q <= ovf_q ? 8'h3F : lut_char;
                  err_q   <= ovf_q | ~lut_hit;
                  valid_q <= 1'b1;
                  sr_q    <= '0;
                  n_q     <= '0;
                  ovf_q   <= 1'b0;
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (key_rise) begin
                  state_q <= MARK;
               end else if (tick && units_q == 3'd4) begin
                  code_q  <= '0;
                  ascii_q <= 8'h20;
                  valid_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ascii_out = ascii_q;
   assign code_out  = code_q;
   assign valid     = valid_q;
   assign err       = err_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with a short unit (4 clocks) so each
// character and word gap fits in a few dozen cycles.
module tb_morse_decoder;

   localparam int U = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_in = 1'b0;
   logic [7:0]  ascii_out;
   logic [15:0] code_out;
   logic        valid;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;
   int viol     = 0;
   logic prev_valid = 1'b0;
   logic [24:0] ev_q[$];

   always #5 clk = ~clk;

   morse_decoder #(.UNIT_CYCLES(U), .DATA_WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in),
      .ascii_out (ascii_out),
      .code_out  (code_out),
      .valid     (valid),
      .err       (err)
   );

   // Capture every strobe; also flag back-to-back strobes and stray err.
   always @(posedge clk) begin
      #1;
      if (valid) begin
         ev_q.push_back({err, ascii_out, code_out});
         $display("strobe: ascii=0x%02h code=0x%04h err=%0b", ascii_out, code_out, err);
      end
      if (valid && prev_valid) viol++;
      if (!valid && err) viol++;
      prev_valid = valid;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic mark(input int n);
      key_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic space(input int n);
      key_in = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_char(input string tag, input logic [7:0] a, input logic [15:0] c, input logic e);
      logic [24:0] ev;
      if (ev_q.size() != 0) begin
         ev = ev_q.pop_front();
         check_eq({tag, " ascii"}, 32'(ev[23:16]), 32'(a));
         check_eq({tag, " code"},  32'(ev[15:0]),  32'(c));
         check_eq({tag, " err"},   32'(ev[24]),    32'(e));
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_eq("reset ascii", 32'(ascii_out), 0);
      check_eq("reset code",  32'(code_out),  0);
      check_eq("reset valid", 32'(valid),     0);
      check_eq("reset err",   32'(err),       0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 'a' then a word space
      mark(4); space(4); mark(12); space(34);
      check_eq("a count", ev_q.size(), 2);
      expect_char("a", 8'h61, 16'hB000, 1'b0);
      expect_char("a wordsp", 8'h20, 16'h0000, 1'b0);

      // '0' with key rising again before 5 units, then 'e' and word space
      for (int i = 0; i < 5; i++) begin mark(12); space(i == 4 ? 12 : 4); end
      mark(4); space(34);
      check_eq("0 count", ev_q.size(), 3);
      expect_char("0", 8'h30, 16'hFFC0, 1'b0);
      expect_char("0 then e", 8'h65, 16'h8000, 1'b0);
      expect_char("0 wordsp", 8'h20, 16'h0000, 1'b0);

      // classification boundary
      mark(7); space(34);
      check_eq("mark7 count", ev_q.size(), 2);
      expect_char("mark7", 8'h65, 16'h8000, 1'b0);
      expect_char("mark7 wordsp", 8'h20, 16'h0000, 1'b0);
      mark(8); space(34);
      check_eq("mark8 count", ev_q.size(), 2);
      expect_char("mark8", 8'h74, 16'hC000, 1'b0);
      expect_char("mark8 wordsp", 8'h20, 16'h0000, 1'b0);

      // nine dots overflow
      for (int i = 0; i < 9; i++) begin mark(4); space(i == 8 ? 34 : 4); end
      check_eq("ovf count", ev_q.size(), 2);
      expect_char("ovf", 8'h3F, 16'hAAAA, 1'b1);
      expect_char("ovf wordsp", 8'h20, 16'h0000, 1'b0);

      // ..-- unmapped
      mark(4); space(4); mark(4); space(4); mark(12); space(4); mark(12); space(34);
      check_eq("unmapped count", ev_q.size(), 2);
      expect_char("unmapped", 8'h3F, 16'hAF00, 1'b1);
      expect_char("unmapped wordsp", 8'h20, 16'h0000, 1'b0);

      // reset in the middle of the second element
      mark(4); space(4); key_in = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0; key_in = 1'b0;
      @(negedge clk);
      check_eq("midrst ascii", 32'(ascii_out), 0);
      check_eq("midrst valid", 32'(valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      space(40);
      check_eq("midrst count", ev_q.size(), 0);
      mark(4); space(34);
      check_eq("post-rst count", ev_q.size(), 2);
      expect_char("post-rst e", 8'h65, 16'h8000, 1'b0);
      expect_char("post-rst wordsp", 8'h20, 16'h0000, 1'b0);

      // long hold saturates to a dash
      mark(200); space(34);
      check_eq("hold count", ev_q.size(), 2);
      expect_char("hold t", 8'h74, 16'hC000, 1'b0);
      expect_char("hold wordsp", 8'h20, 16'h0000, 1'b0);

      // 9-cycle gap splits characters without a word space
      mark(4); space(9); mark(12); space(34);
      check_eq("gap9 count", ev_q.size(), 3);
      expect_char("gap9 e", 8'h65, 16'h8000, 1'b0);
      expect_char("gap9 t", 8'h74, 16'hC000, 1'b0);
      expect_char("gap9 wordsp", 8'h20, 16'h0000, 1'b0);

      check_eq("strobe rules", viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
